// File: rtl/gb_instr_fetch.sv
// ---------------------------------------------------------------------------
// gb_instr_fetch
//   Byte-stream front end for gbprocessor. Incoming program bytes are
//   buffered in a small FIFO. An FSM pops one byte per cycle and assembles
//   an opcode plus an optional d8 immediate. Opcodes the core does not
//   execute are discarded and counted. Each complete instruction is issued
//   as an instruction/data pair, with a one-cycle valid strobe.
//
// Optional feature macro: GB_FETCH_HALT_EN
//   When defined, opcode 0x76 (HALT) parks the FSM in S_HALT until the
//   resume input is asserted. When undefined, 0x76 is an ordinary register
//   op, resume is ignored and halted is tied low.
//
// Parameters
//   DEPTH        FIFO depth in bytes (power of 2, >= 2)
//   CNT_W        width of drop_count
//
// Ports
//   clock        in   rising-edge clock
//   reset        in   asynchronous active-low reset
//   in_byte      in   program byte from upstream
//   in_valid     in   in_byte valid
//   in_ready     out  FIFO not full (transfer = in_valid & in_ready)
//   hold         in   1 = freeze FSM (no pop, no issue); pushes continue
//   resume       in   leave S_HALT (HALT feature only)
//   instruction  out  issued opcode (holds last issued value)
//   data         out  issued immediate, 0x00 for 1-byte ops
//   valid        out  one-cycle issue strobe
//   halted       out  FSM in S_HALT
//   drop_count   out  saturating count of dropped opcodes
//   fifo_level   out  bytes currently buffered, 0..DEPTH
// ---------------------------------------------------------------------------
module gb_instr_fetch #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [7:0]                in_byte,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      hold,
  input  logic                      resume,
  output logic [7:0]                instruction,
  output logic [7:0]                data,
  output logic                      valid,
  output logic                      halted,
  output logic [CNT_W-1:0]          drop_count,
  output logic [$clog2(DEPTH):0]    fifo_level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_OPC  = 2'd0,
    S_IMM  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  // Two-byte load-immediate opcodes: LD r,d8 (0x36 is LD (HL),d8, not executed).
  function automatic logic f_is_imm(input logic [7:0] op);
    return (op[7:6] == 2'b00) && (op[2:0] == 3'b110) && (op != 8'h36);
  endfunction

  // Single-byte register ops: LD r,r' and ALU A,r.
  function automatic logic f_is_reg(input logic [7:0] op);
    return (op[7:6] == 2'b01) || (op[7:6] == 2'b10);
  endfunction

  // HALT only gets special treatment when the feature is built in.
  function automatic logic f_is_halt(input logic [7:0] op);
`ifdef GB_FETCH_HALT_EN
    return (op == 8'h76);
`else
    return (op == 8'h76) && 1'b0;
`endif
  endfunction

  logic [7:0]       r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  state_t           r_state;
  logic [7:0]       r_lat_op;
  logic [7:0]       r_instr;
  logic [7:0]       r_data;
  logic             r_valid;
  logic [CNT_W-1:0] r_drop_cnt;

  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic [7:0]       w_head;
  state_t           w_state_nxt;
  logic             w_issue;
  logic [7:0]       w_issue_op;
  logic [7:0]       w_issue_data;
  logic             w_drop;
  logic             w_latch;

  assign w_full  = (r_count == FULL_LVL);
  assign w_empty = (r_count == '0);
  // Readiness depends only on occupancy, never on this cycle's pop.
  assign w_push  = in_valid && !w_full;
  assign w_head  = r_mem[r_rd_ptr];

  // FIFO storage: data only, no reset needed since reads are gated by level.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= in_byte;
    end
  end

  // FIFO pointers and occupancy; power-of-2 depth lets pointers wrap naturally.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Next-state / decode: at most one byte consumed per cycle.
  always_comb begin
    w_state_nxt  = r_state;
    w_pop        = 1'b0;
    w_issue      = 1'b0;
    w_issue_op   = r_lat_op;
    w_issue_data = 8'h00;
    w_drop       = 1'b0;
    w_latch      = 1'b0;
    case (r_state)
      S_OPC: begin
        if (!hold && !w_empty) begin
          w_pop = 1'b1;
          // HALT is checked first because 0x76 also decodes as a register op.
          if (f_is_halt(w_head)) begin
            w_state_nxt = S_HALT;
          end else if (f_is_reg(w_head)) begin
            w_issue    = 1'b1;
            w_issue_op = w_head;
          end else if (f_is_imm(w_head)) begin
            w_latch     = 1'b1;
            w_state_nxt = S_IMM;
          end else begin
            w_drop = 1'b1;
          end
        end else begin
          w_pop = 1'b0;
        end
      end
      S_IMM: begin
        // Waits here indefinitely for the immediate byte.
        if (!hold && !w_empty) begin
          w_pop        = 1'b1;
          w_issue      = 1'b1;
          w_issue_op   = r_lat_op;
          w_issue_data = w_head;
          w_state_nxt  = S_OPC;
        end else begin
          w_pop = 1'b0;
        end
      end
      S_HALT: begin
`ifdef GB_FETCH_HALT_EN
        if (!hold && resume) begin
          w_state_nxt = S_OPC;
        end else begin
          w_state_nxt = S_HALT;
        end
`else
        w_state_nxt = S_OPC;
`endif
      end
      default: begin
        w_state_nxt = S_OPC;
      end
    endcase
  end

  // FSM state and latched opcode of a pending two-byte instruction.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= S_OPC;
      r_lat_op <= 8'h00;
    end else begin
      r_state <= w_state_nxt;
      if (w_latch) begin
        r_lat_op <= w_head;
      end
    end
  end

  // Issue registers: valid pulses for one cycle, instruction/data hold value.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_instr <= 8'h00;
      r_data  <= 8'h00;
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_issue;
      if (w_issue) begin
        r_instr <= w_issue_op;
        r_data  <= w_issue_data;
      end
    end
  end

  // Saturating drop counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_drop_cnt <= '0;
    end else if (w_drop && (r_drop_cnt != {CNT_W{1'b1}})) begin
      r_drop_cnt <= r_drop_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign in_ready    = !w_full;
  assign instruction = r_instr;
  assign data        = r_data;
  assign valid       = r_valid;
  assign drop_count  = r_drop_cnt;
  assign fifo_level  = r_count;

`ifdef GB_FETCH_HALT_EN
  assign halted = (r_state == S_HALT);
`else
  logic w_unused;
  assign w_unused = resume;
  assign halted   = 1'b0;
`endif

endmodule
